softmax_seq_ctrl: RTL and testbench

// - Sequences one N-element softmax: buffers the input vector, finds its max, issues (x-max) to an

---
 rtl/softmax_pkg.sv | 24 ++
 rtl/sm_vec_buf.sv | 23 ++
 rtl/softmax_seq_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_softmax_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// Shared types and helpers for the softmax sequencer: state/phase encodings,
// default sizing and the saturating max-subtract used on the exp request path.
package softmax_pkg;

  localparam int DEF_DW = 16;
  localparam int DEF_N  = 32;

  typedef enum logic [2:0] {IDLE, LOAD, MAX, EXP, NORM, DONE} seq_state_t;

  // Per-element sub-steps inside EXP and NORM; PH_OUT is only used in NORM.
  typedef enum logic [1:0] {PH_FETCH, PH_REQ, PH_WAIT, PH_OUT} seq_phase_t;

  // a - b with the result clamped at -2^(dw-1); valid for dw <= 31.
  function automatic logic signed [31:0] sat_sub(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int dw);
    logic signed [32:0] diff;
    logic signed [32:0] lo;
    diff = {a[31], a} - {b[31], b};
    lo   = -(33'sd1 <<< (dw - 1));
    return (diff < lo) ? lo[31:0] : diff[31:0];
  endfunction

endpackage

// File: rtl/sm_vec_buf.sv
// N x DW element buffer: one write port, one registered read port.
// Storage is deliberately not reset; every slot is written in LOAD before use.
module sm_vec_buf #(
  parameter  int DW = 16,
  parameter  int N  = 32,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [N];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/softmax_seq_ctrl.sv
// Softmax pass sequencer: LOAD -> MAX -> EXP -> NORM -> DONE around shared exp/div units.
// Optional build macro SOFTMAX_SEQ_PERF_EN adds the perf_cycles busy-cycle counter.
module softmax_seq_ctrl
  import softmax_pkg::*;
#(
  parameter  int DW = DEF_DW,
  parameter  int N  = DEF_N,
  localparam int SW = DW + $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          exp_req_valid,
  input  logic          exp_req_ready,
  output logic [DW-1:0] exp_req_data,
  input  logic          exp_rsp_valid,
  input  logic [DW-1:0] exp_rsp_data,
  output logic          div_req_valid,
  input  logic          div_req_ready,
  output logic [DW-1:0] div_num,
  output logic [SW-1:0] div_den,
  input  logic          div_rsp_valid,
  input  logic [DW-1:0] div_rsp_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic [DW-1:0] max_out
`ifdef SOFTMAX_SEQ_PERF_EN
  ,
  output logic [31:0]   perf_cycles
`endif
);

  localparam int AW = $clog2(N);
  localparam int IW = AW + 1;

  seq_state_t    state_q, state_d;
  seq_phase_t    ph_q, ph_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] max_q, max_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [SW-1:0] sum_q, sum_d;
  logic          buf_we;
  logic [DW-1:0] buf_wdata;
  logic [DW-1:0] rd_data;
  logic          last_idx;
  logic          exp_take;

  sm_vec_buf #(.DW(DW), .N(N)) u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (idx_q[AW-1:0]),
    .wdata_i (buf_wdata),
    .raddr_i (idx_q[AW-1:0]),
    .rdata_o (rd_data)
  );

  assign last_idx = (idx_q == IW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ph_q       <= PH_FETCH;
      idx_q      <= '0;
      max_q      <= '0;
      sum_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      idx_q      <= idx_d;
      max_q      <= max_d;
      sum_q      <= sum_d;
      out_data_q <= out_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    idx_d      = idx_q;
    max_d      = max_q;
    sum_d      = sum_q;
    out_data_d = out_data_q;
    buf_we     = 1'b0;
    buf_wdata  = in_data;
    exp_take   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          idx_d   = '0;
          sum_d   = '0;
          ph_d    = PH_FETCH;
        end
      end
      LOAD: begin
        if (in_valid) begin
          buf_we = 1'b1;
          if (last_idx) begin
            state_d = MAX;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      // Read of slot idx returns one cycle later, so element idx-1 is compared at count idx.
      MAX: begin
        if (idx_q != '0 && (idx_q == IW'(1) || $signed(rd_data) > $signed(max_q)))
          max_d = rd_data;
        if (idx_q == IW'(N)) begin
          state_d = EXP;
          idx_d   = '0;
          ph_d    = PH_FETCH;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      EXP: begin
        case (ph_q)
          PH_FETCH: ph_d = PH_REQ;
          PH_REQ: begin
            if (exp_req_ready) begin
              if (exp_rsp_valid) exp_take = 1'b1;
              else               ph_d     = PH_WAIT;
            end
          end
          PH_WAIT: if (exp_rsp_valid) exp_take = 1'b1;
          default: ph_d = PH_FETCH;
        endcase
        if (exp_take) begin
          buf_we    = 1'b1;
          buf_wdata = exp_rsp_data;
          sum_d     = sum_q + SW'(exp_rsp_data);
          ph_d      = PH_FETCH;
          if (last_idx) begin
            state_d = NORM;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      NORM: begin
        case (ph_q)
          PH_FETCH: ph_d = PH_REQ;
          PH_REQ: begin
            if (div_req_ready) begin
              if (div_rsp_valid) begin
                out_data_d = div_rsp_data;
                ph_d       = PH_OUT;
              end else begin
                ph_d = PH_WAIT;
              end
            end
          end
          PH_WAIT: begin
            if (div_rsp_valid) begin
              out_data_d = div_rsp_data;
              ph_d       = PH_OUT;
            end
          end
          PH_OUT: begin
            if (out_ready) begin
              ph_d = PH_FETCH;
              if (last_idx) begin
                state_d = DONE;
                idx_d   = '0;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end
          end
          default: ph_d = PH_FETCH;
        endcase
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready      = (state_q == LOAD);
  assign exp_req_valid = (state_q == EXP) && (ph_q == PH_REQ);
  assign exp_req_data  = DW'(sat_sub(32'(signed'(rd_data)), 32'(signed'(max_q)), DW));
  assign div_req_valid = (state_q == NORM) && (ph_q == PH_REQ);
  assign div_num       = rd_data;
  assign div_den       = sum_q;
  assign out_valid     = (state_q == NORM) && (ph_q == PH_OUT);
  assign out_data      = out_data_q;
  assign out_last      = out_valid && last_idx;
  assign busy          = (state_q != IDLE);
  assign max_out       = max_q;

`ifdef SOFTMAX_SEQ_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst)                                        perf_q <= '0;
    else if (state_q == IDLE && start)              perf_q <= '0;
    else if (state_q != IDLE && perf_q != '1)       perf_q <= perf_q + 1'b1;
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Scoreboard bench for softmax_seq_ctrl (DW=16, N=4) with exp/div stub models.
module tb_softmax_seq_ctrl;
  localparam int DW = 16;
  localparam int N  = 4;
  localparam int SW = DW + $clog2(N);

  logic clk = 1'b0;
  logic rst, start, in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic exp_req_valid, exp_req_ready, exp_rsp_valid;
  logic [DW-1:0] exp_req_data, exp_rsp_data;
  logic div_req_valid, div_req_ready, div_rsp_valid;
  logic [DW-1:0] div_num, div_rsp_data;
  logic [SW-1:0] div_den;
  logic out_valid, out_ready, out_last, busy;
  logic [DW-1:0] out_data, max_out;
`ifdef SOFTMAX_SEQ_PERF_EN
  logic [31:0] perf_cycles;
`endif

  softmax_seq_ctrl #(.DW(DW), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .exp_req_valid(exp_req_valid), .exp_req_ready(exp_req_ready), .exp_req_data(exp_req_data),
    .exp_rsp_valid(exp_rsp_valid), .exp_rsp_data(exp_rsp_data),
    .div_req_valid(div_req_valid), .div_req_ready(div_req_ready),
    .div_num(div_num), .div_den(div_den),
    .div_rsp_valid(div_rsp_valid), .div_rsp_data(div_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .max_out(max_out)
`ifdef SOFTMAX_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  int exp_q[$];
  int div_q[$];
  int out_q[$];
  int out_cnt = 0;
  int stall_left = 0;
  bit stall_armed = 0;
  logic [DW-1:0] stall_ref;
  int busy_cnt = 0;

  // exp unit stub: fixed result 16, two cycles after the accepted request
  int exp_cnt = 0;
  always @(negedge clk) begin
    exp_rsp_valid = 1'b0;
    if (exp_cnt != 0) begin
      exp_cnt--;
      if (exp_cnt == 0) begin
        exp_rsp_valid = 1'b1;
        exp_rsp_data  = 16'd16;
      end
    end else if (exp_req_valid && exp_req_ready && !rst) begin
      exp_cnt = 2;
      if (exp_q.size() == 0) chk("exp_extra", 1, 0);
      else chk("exp_req_data", $signed(exp_req_data), exp_q.pop_front());
    end
  end

  // divider stub: num*4/den three cycles after the accepted request, random ready
  int div_cnt = 0;
  logic [DW-1:0] div_res;
  always @(negedge clk) begin
    div_rsp_valid = 1'b0;
    if (div_cnt != 0) begin
      div_cnt--;
      if (div_cnt == 0) begin
        div_rsp_valid = 1'b1;
        div_rsp_data  = div_res;
      end
    end else begin
      div_req_ready = ($urandom_range(0, 2) != 0);
      if (div_req_valid && div_req_ready && !rst) begin
        div_cnt = 3;
        div_res = (div_den == 0) ? '0 : DW'((int'(div_num) * 4) / int'(div_den));
        chk("div_num", div_num, 16);
        if (div_q.size() == 0) chk("div_extra", 1, 0);
        else chk("div_den", div_den, div_q.pop_front());
      end
    end
  end

  // result consumer with optional back-pressure on element 1
  always @(negedge clk) begin
    if (out_valid) begin
      if (stall_left > 0 && out_cnt == 1) begin
        out_ready = 1'b0;
        if (!stall_armed) begin
          stall_ref   = out_data;
          stall_armed = 1'b1;
        end else begin
          chk("stall_data", out_data, stall_ref);
        end
        chk("stall_no_div", div_req_valid, 0);
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      if (out_ready) begin
        if (out_q.size() == 0) chk("out_extra", 1, 0);
        else chk("out_data", out_data, out_q.pop_front());
        chk("out_last", out_last, (out_cnt == N - 1));
        out_cnt++;
      end
    end else begin
      out_ready = 1'b1;
    end
  end

  always @(negedge clk) if (busy) busy_cnt++;

  task automatic push_expect(input int v[N], output int mx);
    int d;
    mx = v[0];
    for (int i = 1; i < N; i++) if (v[i] > mx) mx = v[i];
    for (int i = 0; i < N; i++) begin
      d = v[i] - mx;
      if (d < -32768) d = -32768;
      exp_q.push_back(d);
      div_q.push_back(16 * N);
      out_q.push_back((16 * 4) / (16 * N));
    end
  endtask

  task automatic start_and_load(input int v[N]);
    int cyc;
    cyc = 0;
    while (busy && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("idle_before_start", busy, 0);
    out_cnt     = 0;
    stall_armed = 1'b0;
    start       = 1'b1;
    busy_cnt    = 0;
    @(negedge clk);
    start = 1'b0;
`ifdef SOFTMAX_SEQ_PERF_EN
    chk("perf_clear", perf_cycles, 0);
`endif
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(v[i]);
      cyc = 0;
      while (!in_ready && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      chk("load_ready", in_ready, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_vector(input int v[N], input bit start_in_exp, input bit stall);
    int mx, cyc, rdy_seen;
    bit pulsed;
    push_expect(v, mx);
    stall_left = stall ? 5 : 0;
    start_and_load(v);
    cyc = 0;
    rdy_seen = 0;
    pulsed = 1'b0;
    while (busy && cyc < 2000) begin
      start = 1'b0;
      if (in_ready) rdy_seen++;
      if (start_in_exp && !pulsed && exp_req_valid) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("done_in_time", busy, 0);
    chk("in_ready_while_busy", rdy_seen, 0);
    chk("max_out", $signed(max_out), mx);
    chk("exp_left", exp_q.size(), 0);
    chk("div_left", div_q.size(), 0);
    chk("out_count", out_cnt, N);
`ifdef SOFTMAX_SEQ_PERF_EN
    chk("perf_cycles", perf_cycles, busy_cnt);
`endif
    if (start_in_exp) begin
      chk("start_pulsed", pulsed, 1);
      repeat (3) @(negedge clk);
      chk("no_restart", busy, 0);
    end
  endtask

  task automatic reset_mid_exp(input int v[N]);
    int mx, cyc;
    push_expect(v, mx);
    start_and_load(v);
    cyc = 0;
    while (!exp_req_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_exp", exp_req_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_exp_valid", exp_req_valid, 0);
    chk("rst_div_valid", div_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_max_out", max_out, 0);
    exp_q.delete();
    div_q.delete();
    out_q.delete();
    repeat (4) @(negedge clk);
    chk("late_rsp_dropped", busy, 0);
  endtask

  int v1[N] = '{3, -1, 7, 7};
  int v2[N] = '{-32768, 32767, 0, 0};
  int v3[N] = '{5, -20, 100, -3};
  int v4[N] = '{-7, -7, -2, -9};

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    exp_req_ready = 1'b1; exp_rsp_valid = 1'b0; exp_rsp_data = '0;
    div_req_ready = 1'b1; div_rsp_valid = 1'b0; div_rsp_data = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_exp_valid", exp_req_valid, 0);
    chk("reset_div_valid", div_req_valid, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_max_out", max_out, 0);
`ifdef SOFTMAX_SEQ_PERF_EN
    chk("reset_perf", perf_cycles, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    run_vector(v1, 1'b0, 1'b0);
    run_vector(v2, 1'b0, 1'b0);
    run_vector(v1, 1'b0, 1'b1);
    run_vector(v3, 1'b1, 1'b0);
    reset_mid_exp(v1);
    run_vector(v4, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
